lcd_hex_display: RTL and testbench
==================================

Name: lcd_hex_display

Overview:
- Parametrised successor to the single-digit LCD print path; drives the Spartan-3E 16x2 character LCD in 4-bit mode.
- Shows a VALUE_W-bit operand/result as DIGITS upper-case hex characters at line 1, column 0.
- Runs the power-on init once only, so the display does not flicker, then rewrites digits only when a new value arrives.
- Sits between datapath registers (adder result, operands) and the LCD pins; uses a latest-value-wins one-deep update buffer.

Parameters:
- VALUE_W, 8, displayed value width; DIGITS = ceil(VALUE_W/4), 1..16.
- T_SETUP, 2, cycles db/rs are stable before e rises.
- T_EPULSE, 12, cycles e is held high per nibble.
- T_NIB_GAP, 50, cycles between upper and lower nibble of one byte.
- T_CMD, 2000, cycles after each byte (40 us at 50 MHz).
- T_CLEAR, 82000, cycles after the Clear Display byte.
- T_PWRON, 750000, cycles of wait after reset before init (15 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- value  in  VALUE_W  value to display.
- load  in  1  one-cycle strobe; captures value.
- busy  out  1  high while in init or while a write is in progress.
- sf_e  out  1  StrataFlash disable; LCD owns the bus.
- e  out  1  LCD enable strobe.
- rs  out  1  register select: 1 = data, 0 = command.
- rw  out  1  always 0 (write only).
- db  out  4  LCD data nibble; db[3] = D7 pin.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: sf_e=1, e=0, rs=0, rw=0, db=0, busy=1, shadow=0, dirty=1, FSM=PWR_WAIT. Because dirty=1, the first display after init is all '0'.
- Reset mid-operation: outputs return to reset values on the next edge and the full init is replayed. No partial byte completes.
- States and transitions:
  - PWR_WAIT: wait T_PWRON, then go to INIT.
  - INIT: send raw nibble 0x3 three times with waits of 205000, 5000 and T_CMD cycles. Then send nibble 0x2 with wait T_CMD. Then send command bytes 0x28, 0x06, 0x0C, 0x01. The wait after 0x01 is T_CLEAR. Then go to IDLE.
  - IDLE: busy=0. If dirty=1, snapshot shadow into the working register, clear dirty, go to ADDR.
  - ADDR: send command 0x80 (DDRAM address 0), go to DIGIT.
  - DIGIT: send DIGITS data bytes (rs=1), most significant nibble first, then return to IDLE.
- Digit encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46. When VALUE_W is not a multiple of 4, the top digit is zero-extended.
- Byte transfer:
  - Upper nibble: drive rs/db, hold T_SETUP cycles, e=1 for T_EPULSE cycles, e=0, wait T_NIB_GAP.
  - Lower nibble: same sequence, then the post-byte wait (T_CMD or T_CLEAR).
  - db and rs are held stable for the whole e-high window.
- Load buffer:
  - load=1 in any state (including INIT) writes value into shadow and sets dirty=1.
  - Repeated loads overwrite shadow; only the latest value is shown.
  - Load on the same cycle IDLE snapshots: the snapshot takes the old shadow, the new value is stored, and dirty stays 1, so a second write follows.
- busy: rises the cycle after IDLE leaves on a snapshot; falls when IDLE is re-entered.
- No-change case: with no load in IDLE, the bus idles with e=0 and no LCD traffic.

Decomposition:
- Package lcd_pkg holds:
  - FSM state enum: PWR_WAIT, INIT, IDLE, ADDR, DIGIT.
  - Command constants: FUNC_SET=0x28, ENTRY=0x06, DISP_ON=0x0C, CLEAR=0x01, HOME_ADDR=0x80.
  - hex_to_ascii function.
- Sub-module lcd_byte_tx owns the timing counter and the nibble/e sequencing.
  - Inputs: start, byte, rs, nibble_only, long_wait.
  - Outputs: done, e, rs, db.
  - Top level keeps only the sequencing FSM and the load buffer.

Test Plan (sim with T_PWRON=20, T_CMD=10, T_CLEAR=30, T_EPULSE=3, T_NIB_GAP=4; init waits scaled):
- Reset release -> e stays 0 during PWR_WAIT. Nibble sequence is 3,3,3,2, then bytes 28,06,0C,01, then 80,'0','0'; busy falls after that.
- VALUE_W=8, load value 0xA7 -> after 80: data bytes 0x41, 0x37 with rs=1; each byte is two e pulses, upper nibble first.
- VALUE_W=6, load 0x3F -> bytes 0x33, 0x46.
- Load 0x12, then 0x34 during the 0x12 write, then 0x56 one cycle later -> exactly two writes, "12" then "56"; 0x34 is never sent.
- Load on the exact IDLE snapshot cycle -> back-to-back writes; the second write shows the new value.
- rst asserted during the lower nibble of a data byte -> next cycle e=0, db=0, busy=1, and the full init is replayed. A check also confirms db/rs never change while e=1 across all tests.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, LCD command bytes and helpers for the hex display path.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        IDLE     = 3'd2,
        ADDR     = 3'd3,
        DIGIT    = 3'd4
    } lcd_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_SETUP = 3'd1,
        TX_PULSE = 3'd2,
        TX_GAP   = 3'd3,
        TX_POST  = 3'd4
    } tx_phase_t;

    typedef enum logic [1:0] {
        WAIT_CMD   = 2'd0,
        WAIT_CLEAR = 2'd1,
        WAIT_INIT1 = 2'd2,
        WAIT_INIT2 = 2'd3
    } wait_sel_t;

    typedef struct packed {
        logic [7:0] data;
        logic       nib_only;
        wait_sel_t  wsel;
    } tx_item_t;

    localparam logic [7:0] FUNC_SET  = 8'h28;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] HOME_ADDR = 8'h80;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Power-on sequence: three raw 0x3 nibbles, 0x2 to enter 4-bit mode, then setup bytes.
    function automatic tx_item_t init_item(input logic [2:0] idx);
        tx_item_t it;
        it.data     = 8'h03;
        it.nib_only = 1'b1;
        it.wsel     = WAIT_CMD;
        case (idx)
            3'd0: it.wsel = WAIT_INIT1;
            3'd1: it.wsel = WAIT_INIT2;
            3'd2: it.wsel = WAIT_CMD;
            3'd3: it.data = 8'h02;
            3'd4: begin it.data = FUNC_SET; it.nib_only = 1'b0; end
            3'd5: begin it.data = ENTRY;    it.nib_only = 1'b0; end
            3'd6: begin it.data = DISP_ON;  it.nib_only = 1'b0; end
            default: begin it.data = CLEAR; it.nib_only = 1'b0; it.wsel = WAIT_CLEAR; end
        endcase
        return it;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte (or a single raw nibble) over the 4-bit LCD bus with setup,
// enable pulse, inter-nibble gap and post-transfer wait timing.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EPULSE  = 12,
    parameter int unsigned T_NIB_GAP = 50,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       rs_i,
    input  logic       nibble_only_i,
    input  wait_sel_t  wait_sel_i,
    output logic       done_o,
    output logic       e_o,
    output logic       rs_o,
    output logic [3:0] db_o
);

    tx_phase_t   phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] post_q, post_d;
    logic [3:0]  low_q, low_d;
    logic        hi_q, hi_d;
    logic        rs_q, rs_d;
    logic [3:0]  db_q, db_d;
    logic [31:0] post_len;

    always_comb begin
        case (wait_sel_i)
            WAIT_CLEAR: post_len = 32'(T_CLEAR);
            WAIT_INIT1: post_len = 32'(T_INIT1);
            WAIT_INIT2: post_len = 32'(T_INIT2);
            default:    post_len = 32'(T_CMD);
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        post_d  = post_q;
        low_d   = low_q;
        hi_d    = hi_q;
        rs_d    = rs_q;
        db_d    = db_q;
        case (phase_q)
            TX_IDLE: begin
                if (start_i) begin
                    low_d   = byte_i[3:0];
                    hi_d    = !nibble_only_i;
                    rs_d    = rs_i;
                    db_d    = nibble_only_i ? byte_i[3:0] : byte_i[7:4];
                    post_d  = post_len;
                    cnt_d   = 32'(T_SETUP - 1);
                    phase_d = TX_SETUP;
                end
            end
            TX_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = 32'(T_EPULSE - 1);
                    phase_d = TX_PULSE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            TX_PULSE: begin
                if (cnt_q == '0) begin
                    if (hi_q) begin
                        cnt_d   = 32'(T_NIB_GAP - 1);
                        phase_d = TX_GAP;
                    end else begin
                        cnt_d   = post_q - 32'd1;
                        phase_d = TX_POST;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            TX_GAP: begin
                if (cnt_q == '0) begin
                    hi_d    = 1'b0;
                    db_d    = low_q;
                    cnt_d   = 32'(T_SETUP - 1);
                    phase_d = TX_SETUP;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            TX_POST: begin
                if (cnt_q == '0) begin
                    phase_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: phase_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= TX_IDLE;
            cnt_q   <= '0;
            post_q  <= '0;
            low_q   <= '0;
            hi_q    <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            post_q  <= post_d;
            low_q   <= low_d;
            hi_q    <= hi_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
        end
    end

    assign done_o = (phase_q == TX_POST) && (cnt_q == '0);
    assign e_o    = (phase_q == TX_PULSE);
    assign rs_o   = rs_q;
    assign db_o   = db_q;

endmodule

// File: rtl/lcd_hex_display.sv
// Shows a VALUE_W-bit value as upper-case hex at LCD line 1 column 0; init runs
// once after reset, then digits are rewritten only when a new value is loaded.
module lcd_hex_display
    import lcd_pkg::*;
#(
    parameter int unsigned VALUE_W   = 8,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EPULSE  = 12,
    parameter int unsigned T_NIB_GAP = 50,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_PWRON   = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic               busy,
    output logic               sf_e,
    output logic               e,
    output logic               rs,
    output logic               rw,
    output logic [3:0]         db
);

    localparam int unsigned DIGITS = (VALUE_W + 3) / 4;
    localparam int unsigned W4     = 4 * DIGITS;

    lcd_state_t          state_q, state_d;
    logic [3:0]          step_q, step_d;
    logic                sent_q, sent_d;
    logic [31:0]         pwr_cnt_q, pwr_cnt_d;
    logic [VALUE_W-1:0]  shadow_q, shadow_d;
    logic                dirty_q, dirty_d;
    logic [W4-1:0]       work_q, work_d;
    logic                busy_q, busy_d;

    logic       tx_start, tx_rs, tx_nib, tx_done;
    logic [7:0] tx_byte;
    wait_sel_t  tx_wsel;
    tx_item_t   item;
    logic [3:0] idx;
    logic [3:0] digit_nib;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        sent_d    = sent_q;
        pwr_cnt_d = pwr_cnt_q;
        work_d    = work_q;
        shadow_d  = load ? value : shadow_q;
        dirty_d   = load ? 1'b1 : dirty_q;
        tx_start  = 1'b0;
        tx_byte   = 8'h00;
        tx_rs     = 1'b0;
        tx_nib    = 1'b0;
        tx_wsel   = WAIT_CMD;
        item      = init_item(step_q[2:0]);
        idx       = 4'(DIGITS - 1) - step_q;
        digit_nib = 4'(work_q >> {idx, 2'b00});

        // Each byte-issuing state raises start once, then waits for done to advance.
        if (state_q == INIT || state_q == ADDR || state_q == DIGIT) begin
            tx_start = !sent_q;
            if (!sent_q) sent_d = 1'b1;
            if (tx_done) sent_d = 1'b0;
        end

        case (state_q)
            PWR_WAIT: begin
                if (pwr_cnt_q == 32'(T_PWRON - 1)) begin
                    state_d = INIT;
                    step_d  = '0;
                    sent_d  = 1'b0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 32'd1;
                end
            end
            INIT: begin
                tx_byte = item.data;
                tx_nib  = item.nib_only;
                tx_wsel = item.wsel;
                if (tx_done) begin
                    if (step_q == 4'd7) state_d = IDLE;
                    else step_d = step_q + 4'd1;
                end
            end
            IDLE: begin
                // A load on this same cycle lands in shadow and keeps dirty set.
                if (dirty_q) begin
                    work_d              = '0;
                    work_d[VALUE_W-1:0] = shadow_q;
                    dirty_d             = load;
                    sent_d              = 1'b0;
                    state_d             = ADDR;
                end
            end
            ADDR: begin
                tx_byte = HOME_ADDR;
                if (tx_done) begin
                    state_d = DIGIT;
                    step_d  = '0;
                end
            end
            DIGIT: begin
                tx_byte = hex_to_ascii(digit_nib);
                tx_rs   = 1'b1;
                if (tx_done) begin
                    if (step_q == 4'(DIGITS - 1)) state_d = IDLE;
                    else step_d = step_q + 4'd1;
                end
            end
            default: state_d = PWR_WAIT;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PWR_WAIT;
            step_q    <= '0;
            sent_q    <= 1'b0;
            pwr_cnt_q <= '0;
            shadow_q  <= '0;
            dirty_q   <= 1'b1;
            work_q    <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            sent_q    <= sent_d;
            pwr_cnt_q <= pwr_cnt_d;
            shadow_q  <= shadow_d;
            dirty_q   <= dirty_d;
            work_q    <= work_d;
            busy_q    <= busy_d;
        end
    end

    lcd_byte_tx #(
        .T_SETUP   (T_SETUP),
        .T_EPULSE  (T_EPULSE),
        .T_NIB_GAP (T_NIB_GAP),
        .T_CMD     (T_CMD),
        .T_CLEAR   (T_CLEAR),
        .T_INIT1   (T_INIT1),
        .T_INIT2   (T_INIT2)
    ) u_tx (
        .clk           (clk),
        .rst           (rst),
        .start_i       (tx_start),
        .byte_i        (tx_byte),
        .rs_i          (tx_rs),
        .nibble_only_i (tx_nib),
        .wait_sel_i    (tx_wsel),
        .done_o        (tx_done),
        .e_o           (e),
        .rs_o          (rs),
        .db_o          (db)
    );

    assign busy = busy_q;
    assign sf_e = 1'b1;
    assign rw   = 1'b0;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Directed bench: captures every e pulse as {rs,db} on two instances (8-bit and 6-bit values).
module tb_lcd_hex_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] value8;
    logic       load8;
    logic [5:0] value6;
    logic       load6;
    logic       busy8, sf_e8, e8, rs8, rw8;
    logic [3:0] db8;
    logic       busy6, sf_e6, e6, rs6, rw6;
    logic [3:0] db6;

    lcd_hex_display #(
        .VALUE_W(8), .T_SETUP(2), .T_EPULSE(3), .T_NIB_GAP(4), .T_CMD(10),
        .T_CLEAR(30), .T_PWRON(20), .T_INIT1(40), .T_INIT2(20)
    ) dut8 (
        .clk(clk), .rst(rst), .value(value8), .load(load8), .busy(busy8),
        .sf_e(sf_e8), .e(e8), .rs(rs8), .rw(rw8), .db(db8)
    );

    lcd_hex_display #(
        .VALUE_W(6), .T_SETUP(2), .T_EPULSE(3), .T_NIB_GAP(4), .T_CMD(10),
        .T_CLEAR(30), .T_PWRON(20), .T_INIT1(40), .T_INIT2(20)
    ) dut6 (
        .clk(clk), .rst(rst), .value(value6), .load(load6), .busy(busy6),
        .sf_e(sf_e6), .e(e6), .rs(rs6), .rw(rw6), .db(db6)
    );

    int total = 0;
    int bad   = 0;
    logic [4:0] got8[$], got6[$], exp8[$], exp6[$];
    int   viol8 = 0, viol6 = 0;
    logic pe8 = 1'b0, pe6 = 1'b0;
    logic [4:0] lat8 = '0, lat6 = '0;

    // Record each nibble on e rising; flag any rs/db change while e stays high.
    always @(negedge clk) begin
        if (e8 && !pe8) begin
            got8.push_back({rs8, db8});
            lat8 <= {rs8, db8};
        end else if (e8 && pe8 && ({rs8, db8} !== lat8)) begin
            viol8 <= viol8 + 1;
        end
        pe8 <= e8;
    end

    always @(negedge clk) begin
        if (e6 && !pe6) begin
            got6.push_back({rs6, db6});
            lat6 <= {rs6, db6};
        end else if (e6 && pe6 && ({rs6, db6} !== lat6)) begin
            viol6 <= viol6 + 1;
        end
        pe6 <= e6;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic exp_byte(input bit six, input logic r, input logic [7:0] b);
        if (six) begin
            exp6.push_back({r, b[7:4]});
            exp6.push_back({r, b[3:0]});
        end else begin
            exp8.push_back({r, b[7:4]});
            exp8.push_back({r, b[3:0]});
        end
    endtask

    task automatic exp_init(input bit six);
        for (int i = 0; i < 3; i++) begin
            if (six) exp6.push_back(5'h03); else exp8.push_back(5'h03);
        end
        if (six) exp6.push_back(5'h02); else exp8.push_back(5'h02);
        exp_byte(six, 1'b0, 8'h28);
        exp_byte(six, 1'b0, 8'h06);
        exp_byte(six, 1'b0, 8'h0C);
        exp_byte(six, 1'b0, 8'h01);
    endtask

    task automatic check_streams(input string tag);
        chk($sformatf("%s_len8", tag), 32'(got8.size()), 32'(exp8.size()));
        for (int i = 0; i < got8.size() && i < exp8.size(); i++)
            chk($sformatf("%s_w8[%0d]", tag, i), 32'(got8[i]), 32'(exp8[i]));
        chk($sformatf("%s_len6", tag), 32'(got6.size()), 32'(exp6.size()));
        for (int i = 0; i < got6.size() && i < exp6.size(); i++)
            chk($sformatf("%s_w6[%0d]", tag, i), 32'(got6[i]), 32'(exp6[i]));
        got8.delete(); got6.delete(); exp8.delete(); exp6.delete();
    endtask

    task automatic wait_idle(input string tag);
        int run = 0;
        bit ok  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy8 && !busy6) run++;
            else run = 0;
            if (run >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("%s_idle_reached", tag), 32'(ok), 32'd1);
    endtask

    initial begin
        bit reached;
        rst = 1'b1; load8 = 1'b0; load6 = 1'b0; value8 = '0; value6 = '0;
        repeat (3) @(negedge clk);
        chk("rst_e",    32'(e8),    32'd0);
        chk("rst_busy", 32'(busy8), 32'd1);
        chk("rst_sf_e", 32'(sf_e8), 32'd1);
        chk("rst_rw",   32'(rw8),   32'd0);
        chk("rst_db",   32'(db8),   32'd0);
        chk("rst_rs",   32'(rs8),   32'd0);
        chk("rst_busy6", 32'(busy6), 32'd1);

        rst = 1'b0;
        repeat (18) @(negedge clk);
        chk("pwr_quiet8", 32'(got8.size()), 32'd0);
        chk("pwr_quiet6", 32'(got6.size()), 32'd0);
        chk("pwr_busy",   32'(busy8),       32'd1);

        // Power-up: init sequence then an all-'0' display.
        exp_init(1'b0); exp_byte(1'b0, 1'b0, 8'h80); exp_byte(1'b0, 1'b1, 8'h30); exp_byte(1'b0, 1'b1, 8'h30);
        exp_init(1'b1); exp_byte(1'b1, 1'b0, 8'h80); exp_byte(1'b1, 1'b1, 8'h30); exp_byte(1'b1, 1'b1, 8'h30);
        wait_idle("init");
        check_streams("init");

        // 0xA7 on the 8-bit unit, 0x3F on the 6-bit unit.
        value8 = 8'hA7; load8 = 1'b1; value6 = 6'h3F; load6 = 1'b1;
        @(negedge clk);
        load8 = 1'b0; load6 = 1'b0;
        exp_byte(1'b0, 1'b0, 8'h80); exp_byte(1'b0, 1'b1, 8'h41); exp_byte(1'b0, 1'b1, 8'h37);
        exp_byte(1'b1, 1'b0, 8'h80); exp_byte(1'b1, 1'b1, 8'h33); exp_byte(1'b1, 1'b1, 8'h46);
        wait_idle("a7");
        check_streams("a7");

        // 0x12, then 0x34 and 0x56 mid-write: 0x34 is overwritten.
        value8 = 8'h12; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        repeat (5) @(negedge clk);
        value8 = 8'h34; load8 = 1'b1;
        @(negedge clk);
        value8 = 8'h56;
        @(negedge clk);
        load8 = 1'b0;
        exp_byte(1'b0, 1'b0, 8'h80); exp_byte(1'b0, 1'b1, 8'h31); exp_byte(1'b0, 1'b1, 8'h32);
        exp_byte(1'b0, 1'b0, 8'h80); exp_byte(1'b0, 1'b1, 8'h35); exp_byte(1'b0, 1'b1, 8'h36);
        wait_idle("latest");
        check_streams("latest");

        // Second load lands on the snapshot cycle.
        value8 = 8'h9B; load8 = 1'b1;
        @(negedge clk);
        value8 = 8'hC4;
        @(negedge clk);
        load8 = 1'b0;
        exp_byte(1'b0, 1'b0, 8'h80); exp_byte(1'b0, 1'b1, 8'h39); exp_byte(1'b0, 1'b1, 8'h42);
        exp_byte(1'b0, 1'b0, 8'h80); exp_byte(1'b0, 1'b1, 8'h43); exp_byte(1'b0, 1'b1, 8'h34);
        wait_idle("snap");
        check_streams("snap");

        // Reset while the lower nibble of '5' is on the bus.
        value8 = 8'h5E; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (got8.size() >= 4) begin
                reached = 1'b1;
                break;
            end
        end
        chk("mid_reached", 32'(reached), 32'd1);
        if (reached) begin
            chk("mid_upper", 32'(got8[2]), 32'h13);
            chk("mid_lower", 32'(got8[3]), 32'h15);
            chk("mid_e_high", 32'(e8), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_e",    32'(e8),    32'd0);
        chk("mid_rst_db",   32'(db8),   32'd0);
        chk("mid_rst_busy", 32'(busy8), 32'd1);
        chk("mid_rst_rs",   32'(rs8),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        got8.delete(); got6.delete(); exp8.delete(); exp6.delete();
        exp_init(1'b0); exp_byte(1'b0, 1'b0, 8'h80); exp_byte(1'b0, 1'b1, 8'h30); exp_byte(1'b0, 1'b1, 8'h30);
        exp_init(1'b1); exp_byte(1'b1, 1'b0, 8'h80); exp_byte(1'b1, 1'b1, 8'h30); exp_byte(1'b1, 1'b1, 8'h30);
        wait_idle("replay");
        check_streams("replay");

        chk("stable8", 32'(viol8), 32'd0);
        chk("stable6", 32'(viol6), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
